// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register.
// Latency: 1 cycle for non-memory ops; 1 + k cycles for a memory op acked in WAIT cycle k.
// Backpressure: StallM holds EX/MEM and earlier stages while an aligned access is outstanding.
//
// Ports:
//   clock, reset_n                         clock and async active-low reset
//   RegWriteM/MemtoRegM/MemWriteM,
//   ALUOutM/WriteDataM/WriteRegM           EX/MEM bundle (held stable while StallM=1)
//   StallM                                 upstream freeze
//   mem_req/mem_we/mem_addr/mem_wdata      registered data-memory request
//   mem_rdata/mem_ack                      memory response (one-cycle strobe)
//   RegWriteW/MemtoRegW/ReadDataW/
//   ALUOutW/WriteRegW/MisalignW/BusErrW    MEM/WB register outputs
module mem_wb_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        RegWriteM,
   input  logic        MemtoRegM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  WriteRegM,
   output logic        StallM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUOutW,
   output logic [4:0]  WriteRegW,
   output logic        MisalignW,
   output logic        BusErrW
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   // Counter value in the final WAIT cycle; an un-acked access aborts at its end.
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t     state, stateNext;
   logic [7:0] waitCount;

   logic memOp, misal, lastWait;
   logic issue, countInc;
   logic wbBubble, wbKillRw, wbMisal, wbBusErr, wbTakeRdata;

   // Both MemtoRegM and MemWriteM set is treated as a load (mem_we masks it below).
   assign memOp    = MemtoRegM | MemWriteM;
   assign misal    = memOp & (ALUOutM[1:0] != 2'b00);
   assign lastWait = (waitCount == LAST_WAIT);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= stateNext;
   end

   always_comb begin
      stateNext   = state;
      StallM      = 1'b0;
      issue       = 1'b0;
      countInc    = 1'b0;
      wbBubble    = 1'b1;
      wbKillRw    = 1'b0;
      wbMisal     = 1'b0;
      wbBusErr    = 1'b0;
      wbTakeRdata = 1'b0;
      case (state)
         S_IDLE: begin
            if (!memOp) begin
               wbBubble = 1'b0;
            end else if (misal) begin
               wbBubble = 1'b0;
               wbKillRw = 1'b1;
               wbMisal  = 1'b1;
            end else begin
               StallM    = 1'b1;
               issue     = 1'b1;
               stateNext = S_WAIT;
            end
         end
         S_WAIT: begin
            // An ack in the last WAIT cycle takes priority over the abort.
            if (mem_ack) begin
               wbBubble    = 1'b0;
               wbTakeRdata = 1'b1;
               stateNext   = S_IDLE;
            end else if (lastWait) begin
               wbBubble  = 1'b0;
               wbKillRw  = 1'b1;
               wbBusErr  = 1'b1;
               stateNext = S_IDLE;
            end else begin
               StallM   = 1'b1;
               countInc = 1'b1;
            end
         end
         default: stateNext = S_IDLE;
      endcase
      // Reset must release the pipeline immediately, independent of the inputs.
      if (!reset_n) StallM = 1'b0;
   end

   // Memory request registers and wait counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         waitCount <= 8'h0;
      end else if (issue) begin
         mem_req   <= 1'b1;
         mem_we    <= MemWriteM & ~MemtoRegM;
         mem_addr  <= {ALUOutM[31:2], 2'b00};
         mem_wdata <= WriteDataM;
         waitCount <= 8'h0;
      end else if (state == S_WAIT && stateNext == S_IDLE) begin
         mem_req <= 1'b0;
      end else if (countInc) begin
         waitCount <= waitCount + 8'd1;
      end
   end

   // MEM/WB register. Bubbles clear only the control bits; data fields hold.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         ReadDataW <= 32'h0;
         ALUOutW   <= 32'h0;
         WriteRegW <= 5'h0;
         MisalignW <= 1'b0;
         BusErrW   <= 1'b0;
      end else if (wbBubble) begin
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         MisalignW <= 1'b0;
         BusErrW   <= 1'b0;
      end else begin
         RegWriteW <= RegWriteM & ~wbKillRw;
         MemtoRegW <= MemtoRegM;
         ALUOutW   <= ALUOutM;
         WriteRegW <= WriteRegM;
         MisalignW <= wbMisal;
         BusErrW   <= wbBusErr;
         if (wbTakeRdata) ReadDataW <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with TIMEOUT=4.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Every expected value is hand-computed from the stage behaviour.
module tb_mem_wb_stage;

   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        RegWriteM, MemtoRegM, MemWriteM;
   logic [31:0] ALUOutM, WriteDataM;
   logic [4:0]  WriteRegM;
   logic        StallM;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        RegWriteW, MemtoRegW;
   logic [31:0] ReadDataW, ALUOutW;
   logic [4:0]  WriteRegW;
   logic        MisalignW, BusErrW;

   int checks = 0;
   int errors = 0;
   int stalls;

   mem_wb_stage #(.TIMEOUT(TMO)) dut (
      .clock(clock), .reset_n(reset_n),
      .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
      .StallM(StallM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
      .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .MisalignW(MisalignW), .BusErrW(BusErrW)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic setNop();
      RegWriteM  = 1'b0;
      MemtoRegM  = 1'b0;
      MemWriteM  = 1'b0;
      ALUOutM    = 32'h0;
      WriteDataM = 32'h0;
      WriteRegM  = 5'd0;
   endtask

   // Presents one aligned access at the current falling edge, acks it in WAIT
   // cycle ackK (0 = never) and returns at the falling edge after completion.
   task automatic access(input string tag, input logic st, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int ackK, input logic [4:0] dst, output int nStall);
      logic done;
      done       = 1'b0;
      nStall     = 0;
      RegWriteM  = ~st;
      MemtoRegM  = ~st;
      MemWriteM  = st;
      ALUOutM    = addr;
      WriteDataM = wd;
      WriteRegM  = dst;
      for (int c = 0; c <= TMO + 2; c++) begin
         mem_ack   = (ackK > 0 && c == ackK);
         mem_rdata = (ackK > 0 && c == ackK) ? rd : 32'hBAD0_BAD0;
         #1;
         if (c == 0) chk({tag, "_req_idle"}, {31'b0, mem_req}, 32'd0);
         if (c == 1) begin
            chk({tag, "_req"},   {31'b0, mem_req}, 32'd1);
            chk({tag, "_we"},    {31'b0, mem_we},  {31'b0, st});
            chk({tag, "_addr"},  mem_addr, addr);
            chk({tag, "_wdata"}, mem_wdata, wd);
         end
         if (c >= 1) chk({tag, "_bubble"}, {30'b0, RegWriteW, MemtoRegW}, 32'd0);
         done = ~StallM;
         if (StallM) nStall++;
         @(negedge clock);
         mem_ack = 1'b0;
         if (done) break;
      end
      if (!done) chk({tag, "_stall_bound"}, 32'd0, 32'd1);
      setNop();
   endtask

   initial begin
      reset_n   = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      setNop();
      // An aligned load during reset must not raise StallM.
      MemtoRegM = 1'b1;
      ALUOutM   = 32'h100;
      #12;
      chk("rst_stall",  {31'b0, StallM},   32'd0);
      chk("rst_req",    {31'b0, mem_req},  32'd0);
      chk("rst_addr",   mem_addr,          32'd0);
      chk("rst_ctrl",   {27'b0, RegWriteW, MemtoRegW, MisalignW, BusErrW, mem_we}, 32'd0);
      chk("rst_data",   ReadDataW | ALUOutW | {27'b0, WriteRegW}, 32'd0);
      setNop();
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // ALU op: one-cycle pass-through.
      RegWriteM = 1'b1;
      ALUOutM   = 32'h0000_00AA;
      WriteRegM = 5'd5;
      #1;
      chk("alu_stall", {31'b0, StallM}, 32'd0);
      @(negedge clock);
      chk("alu_rw",    {31'b0, RegWriteW}, 32'd1);
      chk("alu_out",   ALUOutW, 32'h0000_00AA);
      chk("alu_reg",   {27'b0, WriteRegW}, 32'd5);
      chk("alu_rd",    ReadDataW, 32'd0);
      chk("alu_flags", {30'b0, MisalignW, BusErrW}, 32'd0);
      setNop();
      #1;
      chk("alu_stall2", {31'b0, StallM}, 32'd0);
      @(negedge clock);

      // Load acked in WAIT cycle 1.
      access("ld", 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 5'd7, stalls);
      chk("ld_stalls", stalls, 32'd1);
      chk("ld_rdata",  ReadDataW, 32'hDEAD_BEEF);
      chk("ld_ctrl",   {30'b0, RegWriteW, MemtoRegW}, 32'd3);
      chk("ld_reg",    {27'b0, WriteRegW}, 32'd7);
      chk("ld_req_done", {31'b0, mem_req}, 32'd0);
      @(negedge clock);

      // Store acked in WAIT cycle 3.
      access("st", 1'b1, 32'h204, 32'h1234_5678, 32'h5555_AAAA, 3, 5'd0, stalls);
      chk("st_stalls", stalls, 32'd3);
      chk("st_ctrl",   {30'b0, RegWriteW, MemtoRegW}, 32'd0);
      chk("st_alu",    ALUOutW, 32'h204);
      chk("st_req_done", {31'b0, mem_req}, 32'd0);
      @(negedge clock);

      // Misaligned load: no access, flagged in WB.
      RegWriteM = 1'b1;
      MemtoRegM = 1'b1;
      ALUOutM   = 32'h102;
      WriteRegM = 5'd3;
      #1;
      chk("mis_stall", {31'b0, StallM}, 32'd0);
      @(negedge clock);
      chk("mis_flag", {31'b0, MisalignW}, 32'd1);
      chk("mis_rw",   {31'b0, RegWriteW}, 32'd0);
      chk("mis_req",  {31'b0, mem_req},   32'd0);
      chk("mis_alu",  ALUOutW, 32'h102);
      setNop();
      @(negedge clock);
      chk("mis_clear", {31'b0, MisalignW}, 32'd0);

      // Stray ack in IDLE is ignored.
      mem_ack   = 1'b1;
      mem_rdata = 32'h0BAD_0BAD;
      @(negedge clock);
      mem_ack = 1'b0;
      chk("stray_rdata", ReadDataW, 32'h5555_AAAA);
      chk("stray_req",   {31'b0, mem_req}, 32'd0);

      // Timeout with no ack.
      access("tmo", 1'b0, 32'h300, 32'h0, 32'h0, 0, 5'd9, stalls);
      chk("tmo_stalls", stalls, TMO);
      chk("tmo_buserr", {31'b0, BusErrW},   32'd1);
      chk("tmo_rw",     {31'b0, RegWriteW}, 32'd0);
      chk("tmo_req",    {31'b0, mem_req},   32'd0);
      chk("tmo_rdata",  ReadDataW, 32'h5555_AAAA);
      @(negedge clock);
      chk("tmo_clear",  {31'b0, BusErrW}, 32'd0);

      // Ack in the last WAIT cycle wins over the abort.
      access("late", 1'b0, 32'h308, 32'h0, 32'hCAFE_F00D, TMO, 5'd10, stalls);
      chk("late_stalls", stalls, TMO);
      chk("late_buserr", {31'b0, BusErrW},   32'd0);
      chk("late_rw",     {31'b0, RegWriteW}, 32'd1);
      chk("late_rdata",  ReadDataW, 32'hCAFE_F00D);
      @(negedge clock);

      // Reset asserted in WAIT cycle 2.
      RegWriteM = 1'b1;
      MemtoRegM = 1'b1;
      ALUOutM   = 32'h400;
      WriteRegM = 5'd12;
      @(negedge clock);
      #1;
      chk("ra_req_pre", {31'b0, mem_req}, 32'd1);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("ra_req",   {31'b0, mem_req}, 32'd0);
      chk("ra_stall", {31'b0, StallM},  32'd0);
      chk("ra_rdata", ReadDataW, 32'd0);
      chk("ra_alu",   ALUOutW,   32'd0);
      chk("ra_ctrl",  {27'b0, RegWriteW, MemtoRegW, MisalignW, BusErrW, 1'b0} | {27'b0, WriteRegW}, 32'd0);
      setNop();
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      mem_ack   = 1'b1;
      mem_rdata = 32'h7777_7777;
      @(negedge clock);
      mem_ack = 1'b0;
      #1;
      chk("ra_late_rdata", ReadDataW, 32'd0);
      chk("ra_late_req",   {31'b0, mem_req},   32'd0);
      chk("ra_late_stall", {31'b0, StallM},    32'd0);
      chk("ra_late_rw",    {31'b0, RegWriteW}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register. It sits directly downstream of the EX/MEM register and consumes its outputs. It performs word loads and stores over a variable-latency req/ack data-memory port and stalls the upstream pipeline while an access is outstanding. It registers the write-back bundle for the WB stage and flags misaligned accesses and bus timeouts.

## Interface
- TIMEOUT, 16: maximum cycles spent in WAIT before an access is aborted; legal range 1..255.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- RegWriteM, MemtoRegM, MemWriteM  in  1 each  control bits from EX/MEM. MemtoRegM=1 means load; MemWriteM=1 means store.
- ALUOutM  in  32  byte address for memory ops, otherwise the ALU result.
- WriteDataM  in  32  store data.
- WriteRegM  in  5  destination register.
- StallM  out  1  freezes EX/MEM and all earlier stages while high.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  32  registered; word aligned.
- mem_wdata  out  32  registered write data.
- mem_rdata  in  32  read data; valid only in a cycle where mem_ack=1.
- mem_ack  in  1  one-cycle completion strobe.
- RegWriteW, MemtoRegW  out  1 each  write-back controls.
- ReadDataW, ALUOutW  out  32 each  load data and ALU result.
- WriteRegW  out  5  destination register.
- MisalignW, BusErrW  out  1 each  exception flags for the instruction currently in WB.

## Operation
- Memory op: memop = MemtoRegM | MemWriteM. Both bits set together is illegal and is treated as a load.
- Misalignment: misal = memop & (ALUOutM[1:0] != 0).
- FSM states are IDLE and WAIT.
- IDLE, no memop:
  - StallM=0.
  - MEM/WB loads the inputs; ReadDataW holds its previous value.
  - MisalignW=0, BusErrW=0.
- IDLE, misal:
  - No access is made; StallM=0.
  - MEM/WB loads the inputs with RegWriteW forced to 0 and MisalignW=1.
- IDLE, aligned memop:
  - StallM=1 (combinational).
  - At the edge: mem_req←1, mem_we←MemWriteM & ~MemtoRegM, mem_addr←ALUOutM, mem_wdata←WriteDataM, counter←0, state→WAIT.
  - MEM/WB loads a bubble: RegWriteW=0, MemtoRegW=0, flags 0.
- WAIT, mem_ack=1:
  - StallM=0 in that same cycle, so upstream advances.
  - At the edge: MEM/WB loads the held EX/MEM bundle with ReadDataW←mem_rdata. mem_req←0, state→IDLE.
- WAIT, no ack, counter = TIMEOUT-1:
  - StallM=0.
  - At the edge: abort, mem_req←0. MEM/WB loads the bundle with RegWriteW=0 and BusErrW=1, and ReadDataW is unchanged. state→IDLE.
- WAIT, otherwise: StallM=1, counter+1, MEM/WB loads a bubble.
- Upstream holds the EX/MEM outputs stable while StallM=1. The block relies on this and does not re-latch the bundle.
- mem_ack outside WAIT is ignored.
- Reset (asynchronous, any state):
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0.
  - All W outputs are 0.
  - StallM=0 while reset_n=0.
  - An access in flight is abandoned; a late mem_ack after reset is ignored.

## Timing
- Non-memory op: 1-cycle latency, EX/MEM to W outputs.
- Aligned memory op presented in cycle N:
  - mem_req is high from cycle N+1.
  - If the earliest ack arrives in N+1, W outputs are valid after the edge ending N+1, which is 2 cycles of latency.
  - StallM is high in N, and low in the ack cycle.
- Ack arriving in WAIT cycle k (k=1..TIMEOUT): StallM is high for exactly k cycles.
- Timeout: the abort edge ends WAIT cycle TIMEOUT. A mem_ack in that same cycle wins and completes normally.
- Back-to-back memory ops: the second op is seen in IDLE in the cycle after the ack. mem_req therefore drops for at least one cycle between accesses.

## Test plan
- Reset, then an ALU op (RegWriteM=1, ALUOutM=0x0000_00AA, WriteRegM=5) → next edge RegWriteW=1, ALUOutW=0xAA, WriteRegW=5, StallM=0 throughout.
- Load from 0x100 with ack in WAIT cycle 1 returning 0xDEAD_BEEF:
  - mem_req=1, mem_we=0, mem_addr=0x100 for 1 cycle.
  - StallM high 1 cycle.
  - Then ReadDataW=0xDEAD_BEEF, MemtoRegW=1.
- Store to 0x204 of 0x1234_5678 with ack after 3 WAIT cycles:
  - mem_we=1, mem_wdata=0x1234_5678.
  - StallM high 3 cycles, bubbles in WB during the stall.
  - RegWriteW=0 at completion.
- Load to 0x102 → no mem_req, StallM=0, next edge MisalignW=1, RegWriteW=0.
- TIMEOUT=4, load with no ack → StallM high 4 cycles, then BusErrW=1, RegWriteW=0, mem_req=0. A repeat run with ack in WAIT cycle 4 completes normally.
- Assert reset_n=0 during WAIT cycle 2 → mem_req and StallM drop immediately, all W outputs are 0. An ack pulsed after reset release has no effect.
